// File: rtl/dht11_pkg.sv
// Shared definitions for the DHT11 single-wire responder (sensor side).
// Holds the FSM state type, the fixed protocol phase lengths in microseconds,
// and the frame checksum helper.
package dht11_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START_LOW,
      RESP_WAIT,
      RESP_LOW,
      RESP_HIGH,
      BIT_LOW,
      BIT_HIGH,
      END_LOW
   } dht_state_e;

   localparam int RESP_LOW_US  = 80;
   localparam int RESP_HIGH_US = 80;
   localparam int BIT_LOW_US   = 50;
   localparam int END_LOW_US   = 50;
   localparam int FRAME_BITS   = 40;

   // Microsecond counter width: wide enough for the start-pulse qualification
   // (tens of milliseconds); the counter saturates rather than wrapping.
   localparam int US_W = 16;

   // Checksum is the byte sum truncated to 8 bits.
   function automatic logic [7:0] frame_chk(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
      return a + b + c + d;
   endfunction

endpackage

// File: rtl/dht11_us_timer.sv
// Microsecond timebase: a prescaler counting 0..TICKS_PER_US-1 and a
// saturating microsecond counter. Both clear synchronously on 'clear'.
// Ports:
//   clk      - system clock
//   rst      - synchronous, active-high reset
//   clear    - restart the timebase from zero on the next cycle
//   us_tick  - high on the last prescaler cycle of each microsecond
//   us_count - completed microseconds since the last clear (saturating)
module dht11_us_timer
   import dht11_pkg::*;
#(
   parameter int TICKS_PER_US = 50
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clear,
   output logic            us_tick,
   output logic [US_W-1:0] us_count
);

   localparam int PRE_W = (TICKS_PER_US > 1) ? $clog2(TICKS_PER_US) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICKS_PER_US - 1);

   logic [PRE_W-1:0] pre_q, pre_d;
   logic [US_W-1:0]  us_q, us_d;

   always_comb begin
      pre_d = pre_q;
      us_d  = us_q;
      if (clear) begin
         pre_d = '0;
         us_d  = '0;
      end else if (pre_q == PRE_LAST) begin
         pre_d = '0;
         if (us_q != '1) begin
            us_d = us_q + 1'b1;
         end
      end else begin
         pre_d = pre_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_q <= '0;
         us_q  <= '0;
      end else begin
         pre_q <= pre_d;
         us_q  <= us_d;
      end
   end

   assign us_tick  = (pre_q == PRE_LAST);
   assign us_count = us_q;

endmodule

// File: rtl/dht11_responder.sv
// DHT11 sensor-side responder. Qualifies the host start pulse, then sends the
// response preamble and a 40-bit frame {HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC,
// CHK}, MSB first, through an external open-drain style tri-state buffer.
// Ports:
//   CLK, RST        - clock, synchronous active-high reset
//   ENABLE          - responder armed; low aborts to IDLE with the bus released
//   HUM_*, TEMP_*   - payload bytes, sampled only when a start is accepted
//   BUS_READ        - bus level from the tri-state (asynchronous)
//   BUS_DIR         - 1 = drive the bus, 0 = release
//   BUS_SEND        - level driven when BUS_DIR=1 (always 0)
//   BUSY            - high from start acceptance to frame end
//   DONE            - one-cycle pulse on frame completion
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | bus released, waiting for the host to pull low
// START_LOW | timing the host low pulse
// RESP_WAIT | released gap before the response
// RESP_LOW  | driving the 80 us response low
// RESP_HIGH | released 80 us response high
// BIT_LOW   | driving the 50 us low that precedes every data bit
// BIT_HIGH  | released; length encodes the current bit
// END_LOW   | driving the 50 us trailing low, then back to IDLE
module dht11_responder
   import dht11_pkg::*;
#(
   parameter int TICKS_PER_US  = 50,
   parameter int START_MIN_US  = 18000,
   parameter int RESP_DELAY_US = 30,
   parameter int BIT0_HIGH_US  = 27,
   parameter int BIT1_HIGH_US  = 70
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       ENABLE,
   input  logic [7:0] HUM_INT,
   input  logic [7:0] HUM_DEC,
   input  logic [7:0] TEMP_INT,
   input  logic [7:0] TEMP_DEC,
   input  logic       BUS_READ,
   output logic       BUS_DIR,
   output logic       BUS_SEND,
   output logic       BUSY,
   output logic       DONE
);

   dht_state_e state_q, state_d;
   logic [1:0]            sync_q, sync_d;
   logic [FRAME_BITS-1:0] frame_q, frame_d;
   logic [5:0]            idx_q, idx_d;
   logic                  done_q, done_d;

   logic            bus_s;
   logic            timer_clear;
   logic            us_tick;
   logic [US_W-1:0] us_count;
   logic [US_W-1:0] phase_us;
   logic            phase_end;

   assign sync_d = {sync_q[0], BUS_READ};
   assign bus_s  = sync_q[1];

   // Any state change restarts the timebase, so each phase of N us lasts
   // exactly N * TICKS_PER_US cycles.
   assign timer_clear = (state_d != state_q);

   dht11_us_timer #(
      .TICKS_PER_US(TICKS_PER_US)
   ) u_timer (
      .clk     (CLK),
      .rst     (RST),
      .clear   (timer_clear),
      .us_tick (us_tick),
      .us_count(us_count)
   );

   always_comb begin
      phase_us = '0;
      case (state_q)
         RESP_WAIT: phase_us = US_W'(RESP_DELAY_US);
         RESP_LOW:  phase_us = US_W'(RESP_LOW_US);
         RESP_HIGH: phase_us = US_W'(RESP_HIGH_US);
         BIT_LOW:   phase_us = US_W'(BIT_LOW_US);
         BIT_HIGH:  phase_us = frame_q[idx_q] ? US_W'(BIT1_HIGH_US) : US_W'(BIT0_HIGH_US);
         END_LOW:   phase_us = US_W'(END_LOW_US);
         default:   phase_us = '0;
      endcase
   end

   // Last cycle of the current timed phase.
   assign phase_end = us_tick && (us_count == phase_us - 1'b1);

   always_comb begin
      state_d = state_q;
      frame_d = frame_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      if (!ENABLE) begin
         state_d = IDLE;
      end else begin
         case (state_q)
            IDLE: begin
               if (!bus_s) state_d = START_LOW;
            end
            START_LOW: begin
               if (bus_s) begin
                  if (us_count >= US_W'(START_MIN_US)) begin
                     frame_d = {HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC,
                                frame_chk(HUM_INT, HUM_DEC, TEMP_INT, TEMP_DEC)};
                     state_d = RESP_WAIT;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
            RESP_WAIT: begin
               if (phase_end) state_d = RESP_LOW;
            end
            RESP_LOW: begin
               if (phase_end) state_d = RESP_HIGH;
            end
            RESP_HIGH: begin
               if (phase_end) begin
                  state_d = BIT_LOW;
                  idx_d   = 6'(FRAME_BITS - 1);
               end
            end
            BIT_LOW: begin
               if (phase_end) state_d = BIT_HIGH;
            end
            BIT_HIGH: begin
               if (phase_end) begin
                  if (idx_q != '0) begin
                     idx_d   = idx_q - 1'b1;
                     state_d = BIT_LOW;
                  end else begin
                     state_d = END_LOW;
                  end
               end
            end
            END_LOW: begin
               if (phase_end) begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   // The synchronizer resets to the idle (high) bus level so a reset never
   // looks like the leading edge of a start pulse.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         sync_q  <= 2'b11;
         frame_q <= '0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync_q  <= sync_d;
         frame_q <= frame_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   // Decoded straight from the state register so a reset or abort releases
   // the bus on the very next edge.
   assign BUS_DIR  = (state_q == RESP_LOW) || (state_q == BIT_LOW) || (state_q == END_LOW);
   assign BUS_SEND = 1'b0;
   assign BUSY     = !((state_q == IDLE) || (state_q == START_LOW));
   assign DONE     = done_q;

endmodule

// File: tb/tb_dht11_responder.sv
// Self-checking bench for dht11_responder with scaled-down timing parameters.
module tb_dht11_responder;

   localparam int T    = 2;
   localparam int SMIN = 100;
   localparam int RD   = 30;
   localparam int B0   = 8;
   localparam int B1   = 20;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable;
   logic [7:0] hum_int, hum_dec, temp_int, temp_dec;
   logic       host_low;
   logic       bus_read;
   logic       bus_dir, bus_send, busy, done;

   // Open-drain bus: low if the host or the responder pulls it down.
   assign bus_read = !(host_low || (bus_dir && !bus_send));

   always #5 clk = ~clk;

   dht11_responder #(
      .TICKS_PER_US (T),
      .START_MIN_US (SMIN),
      .RESP_DELAY_US(RD),
      .BIT0_HIGH_US (B0),
      .BIT1_HIGH_US (B1)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .ENABLE  (enable),
      .HUM_INT (hum_int),
      .HUM_DEC (hum_dec),
      .TEMP_INT(temp_int),
      .TEMP_DEC(temp_dec),
      .BUS_READ(bus_read),
      .BUS_DIR (bus_dir),
      .BUS_SEND(bus_send),
      .BUSY    (busy),
      .DONE    (done)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic summary_and_finish();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
         if (n_bad >= 200) summary_and_finish();
      end
   endtask

   // ---------------- behavioural model ----------------
   // Each entry is the expected {BUS_DIR, BUSY, DONE} for one cycle.
   logic [2:0] q[$];
   logic [2:0] exp_now = 3'b000;
   int         low_run = 0;

   function automatic logic [7:0] model_chk(input int a, input int b, input int c, input int d);
      return 8'((a + b + c + d) % 256);
   endfunction

   function automatic void push_n(input int n, input logic [2:0] v);
      for (int i = 0; i < n; i++) q.push_back(v);
   endfunction

   function automatic void build_frame(input logic [39:0] f);
      push_n(2, 3'b000);              // synchronizer latency after release
      push_n(RD * T, 3'b010);
      push_n(80 * T, 3'b110);
      push_n(80 * T, 3'b010);
      for (int i = 39; i >= 0; i--) begin
         push_n(50 * T, 3'b110);
         push_n((f[i] ? B1 : B0) * T, 3'b010);
      end
      push_n(50 * T, 3'b110);
      push_n(1, 3'b001);
   endfunction

   always @(posedge clk) begin
      if (rst || !enable) begin
         q.delete();
         low_run = 0;
      end else if (q.size() == 0) begin
         if (host_low) begin
            low_run++;
         end else begin
            // First observed low cycle is spent noticing it; the rest is timed.
            if (low_run > 0 && (low_run - 1) >= SMIN * T)
               build_frame({hum_int, hum_dec, temp_int, temp_dec,
                            model_chk(hum_int, hum_dec, temp_int, temp_dec)});
            low_run = 0;
         end
      end
      exp_now = (q.size() != 0) ? q.pop_front() : 3'b000;
   end

   logic checking = 1'b0;
   always @(negedge clk) begin
      if (checking)
         check("outputs{dir,busy,done,send}", {bus_dir, busy, done, bus_send}, {exp_now, 1'b0});
   end

   // ---------------- waveform decoder ----------------
   int         zero_runs[$];
   int         one_runs[$];
   int         run_len = 0;
   logic       run_dir = 1'b0;
   logic       prev_dir = 1'b0;
   int         dir_rises = 0;
   int         done_cnt = 0;
   logic       any_busy = 1'b0;
   logic       any_dir = 1'b0;
   logic [39:0] dec_frame;
   int dec_zero_n, dec_one_n, dec_gap, dec_rlow, dec_rhigh, dec_end;
   int dec_ones, bad_low, bad_high;

   always @(negedge clk) begin
      if (bus_dir && !prev_dir) dir_rises++;
      prev_dir = bus_dir;
      if (busy) any_busy = 1'b1;
      if (bus_dir) any_dir = 1'b1;
      if (done) begin
         done_cnt++;
         if (run_len > 0) begin
            if (run_dir) one_runs.push_back(run_len);
            else zero_runs.push_back(run_len);
         end
         dec_zero_n = zero_runs.size();
         dec_one_n  = one_runs.size();
         dec_frame  = '0;
         dec_ones   = 0;
         bad_low    = 0;
         bad_high   = 0;
         if (dec_zero_n == 42 && dec_one_n == 42) begin
            dec_gap   = zero_runs[0];
            dec_rlow  = one_runs[0];
            dec_rhigh = zero_runs[1];
            dec_end   = one_runs[41];
            for (int i = 0; i < 40; i++) begin
               dec_frame = {dec_frame[38:0], zero_runs[i+2] > ((B0 + B1) * T / 2)};
               if (zero_runs[i+2] != B0 * T && zero_runs[i+2] != B1 * T) bad_high++;
               if (zero_runs[i+2] == B1 * T) dec_ones++;
               if (one_runs[i+1] != 50 * T) bad_low++;
            end
         end
         zero_runs.delete();
         one_runs.delete();
         run_len = 0;
      end else if (busy) begin
         if (run_len != 0 && bus_dir == run_dir) begin
            run_len++;
         end else begin
            if (run_len != 0) begin
               if (run_dir) one_runs.push_back(run_len);
               else zero_runs.push_back(run_len);
            end
            run_dir = bus_dir;
            run_len = 1;
         end
      end else begin
         zero_runs.delete();
         one_runs.delete();
         run_len = 0;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic start_pulse(input int l);
      @(negedge clk);
      host_low = 1'b1;
      repeat (l) @(negedge clk);
      host_low = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0 = done_cnt;
      int k = 0;
      while (done_cnt == d0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      check({name, "_done_seen"}, (done_cnt != d0), 1'b1);
   endtask

   task automatic wait_rises(input int n, input int budget);
      int r0 = dir_rises;
      int k = 0;
      while ((dir_rises - r0) < n && k < budget) begin
         @(posedge clk);
         k++;
      end
      check("bus_dir_rise_wait", ((dir_rises - r0) >= n), 1'b1);
   endtask

   task automatic set_payload(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
      hum_int = a; hum_dec = b; temp_int = c; temp_dec = d;
   endtask

   initial begin
      #900000;
      n_bad++;
      $display("FAIL watchdog: simulation time limit reached");
      summary_and_finish();
   end

   initial begin
      logic [7:0] r0, r1, r2, r3;
      int d0;
      rst = 1'b1;
      enable = 1'b1;
      host_low = 1'b0;
      set_payload(8'h37, 8'h00, 8'h19, 8'h05);
      @(negedge clk);
      checking = 1'b1;
      check("reset_bus_dir", bus_dir, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_done", done, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (10) @(negedge clk);

      // Nominal frame
      start_pulse(SMIN * T + 20);
      wait_done("nominal", 10000);
      check("nominal_frame", dec_frame, 40'h37_00_19_05_55);
      check("nominal_zero_runs", dec_zero_n, 42);
      check("nominal_resp_gap", dec_gap, RD * T);
      check("nominal_resp_low", dec_rlow, 80 * T);
      check("nominal_resp_high", dec_rhigh, 80 * T);
      check("nominal_end_low", dec_end, 50 * T);
      check("nominal_bad_bit_lows", bad_low, 0);
      check("nominal_bad_bit_highs", bad_high, 0);
      check("nominal_one_bits", dec_ones, 14);
      check("nominal_done_count", done_cnt, 1);
      repeat (20) @(negedge clk);

      // Short starts: well short, and one cycle short of the threshold
      any_busy = 1'b0;
      any_dir = 1'b0;
      start_pulse(SMIN * T / 2);
      repeat (50) @(negedge clk);
      start_pulse(SMIN * T);
      repeat (50) @(negedge clk);
      check("short_busy_seen", any_busy, 1'b0);
      check("short_dir_seen", any_dir, 1'b0);
      check("short_done_count", done_cnt, 1);
      start_pulse(SMIN * T + 1);
      wait_done("threshold", 10000);
      check("threshold_frame", dec_frame, 40'h37_00_19_05_55);
      repeat (20) @(negedge clk);

      // Checksum wrap
      set_payload(8'hFF, 8'hFF, 8'h01, 8'h02);
      start_pulse(SMIN * T + 5);
      wait_done("wrap", 10000);
      check("wrap_frame", dec_frame, 40'hFF_FF_01_02_01);
      repeat (20) @(negedge clk);

      // Payload latching
      set_payload(8'hA5, 8'h3C, 8'h5A, 8'hC3);
      start_pulse(SMIN * T + 7);
      repeat (1000) @(negedge clk);
      set_payload(8'h00, 8'h00, 8'h00, 8'h00);
      wait_done("latch", 10000);
      check("latch_frame", dec_frame, 40'hA5_3C_5A_C3_FE);
      repeat (20) @(negedge clk);

      // Enable abort during bit 10 (12th driven low of the frame)
      set_payload(8'h37, 8'h00, 8'h19, 8'h05);
      d0 = done_cnt;
      start_pulse(SMIN * T + 3);
      wait_rises(12, 10000);
      repeat (5) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("abort_bus_dir", bus_dir, 1'b0);
      check("abort_busy", busy, 1'b0);
      repeat (50) @(negedge clk);
      check("abort_no_done", done_cnt - d0, 0);
      enable = 1'b1;
      repeat (10) @(negedge clk);
      start_pulse(SMIN * T + 9);
      wait_done("after_abort", 10000);
      check("after_abort_frame", dec_frame, 40'h37_00_19_05_55);
      repeat (20) @(negedge clk);

      // Reset during RESP_LOW
      d0 = done_cnt;
      start_pulse(SMIN * T + 2);
      wait_rises(1, 2000);
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check("midreset_bus_dir", bus_dir, 1'b0);
      check("midreset_busy", busy, 1'b0);
      check("midreset_done", done, 1'b0);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("midreset_no_done", done_cnt - d0, 0);

      // Two back-to-back random frames
      for (int n = 0; n < 2; n++) begin
         r0 = 8'($urandom_range(0, 255));
         r1 = 8'($urandom_range(0, 255));
         r2 = 8'($urandom_range(0, 255));
         r3 = 8'($urandom_range(0, 255));
         set_payload(r0, r1, r2, r3);
         start_pulse(SMIN * T + 1 + int'($urandom_range(0, 60)));
         wait_done("random", 10000);
         check("random_frame", dec_frame, {r0, r1, r2, r3, model_chk(r0, r1, r2, r3)});
         check("random_bad_bit_highs", bad_high, 0);
         repeat (20) @(negedge clk);
      end

      summary_and_finish();
   end

endmodule
